// File: rtl/wb_port_arbiter_if.sv
// Bundle between the FU result producers and the write-back / completion ports.
// The arbiter uses the slave modport; the FU/consumer side uses master.
interface wb_port_arbiter_if #(
  parameter int unsigned NR_REQ   = 4,
  parameter int unsigned NR_PORTS = 2,
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned ID_W     = 6,
  parameter int unsigned RD_W     = 6
);
  logic [NR_REQ-1:0]               req_valid_i;
  logic [NR_REQ-1:0]               req_ready_o;
  logic [NR_REQ-1:0][DATA_W-1:0]   req_data_i;
  logic [NR_REQ-1:0][ID_W-1:0]     req_id_i;
  logic [NR_REQ-1:0][RD_W-1:0]     req_rd_i;
  logic [NR_PORTS-1:0]             wb_valid_o;
  logic [NR_PORTS-1:0][DATA_W-1:0] wb_data_o;
  logic [NR_PORTS-1:0][RD_W-1:0]   wb_rd_o;
  logic [NR_PORTS-1:0]             compl_valid_o;
  logic [NR_PORTS-1:0][ID_W-1:0]   compl_id_o;

  modport slave (
    input  req_valid_i, req_data_i, req_id_i, req_rd_i,
    output req_ready_o, wb_valid_o, wb_data_o, wb_rd_o, compl_valid_o, compl_id_o
  );

  modport master (
    output req_valid_i, req_data_i, req_id_i, req_rd_i,
    input  req_ready_o, wb_valid_o, wb_data_o, wb_rd_o, compl_valid_o, compl_id_o
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Write-back port arbiter: 2-entry result buffer per FU, round-robin grant of
// up to NR_PORTS buffered heads per cycle onto the write-back/completion ports.
module wb_port_arbiter #(
  parameter int unsigned NR_REQ   = 4,
  parameter int unsigned NR_PORTS = 2,
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned ID_W     = 6,
  parameter int unsigned RD_W     = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  wb_port_arbiter_if.slave  port_if,
  output logic [31:0]       stall_cnt_o
);
  localparam int unsigned       IDX_W      = $clog2(NR_REQ);
  localparam int unsigned       CNT_W      = $clog2(NR_PORTS + 1);
  localparam logic [IDX_W:0]    NR_REQ_L   = (IDX_W + 1)'(NR_REQ);
  localparam logic [CNT_W-1:0]  NR_PORTS_L = CNT_W'(NR_PORTS);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ID_W-1:0]   id;
    logic [RD_W-1:0]   rd;
  } entry_t;

  entry_t              buf_q  [NR_REQ][2];
  logic [1:0]          cnt_q  [NR_REQ];
  logic [1:0]          cnt_d  [NR_REQ];
  logic [NR_REQ-1:0]   head_q, head_d;
  logic [IDX_W-1:0]    rr_q, rr_d;
  logic [31:0]         stall_cnt_q, stall_cnt_d;
  logic [NR_REQ-1:0]   ready, enq, granted;
  logic [NR_PORTS-1:0] port_vld;
  logic [IDX_W-1:0]    port_idx [NR_PORTS];

  // Ready comes from the registered count only; no same-cycle dequeue bypass.
  always_comb begin
    for (int unsigned i = 0; i < NR_REQ; i++) begin
      ready[i] = (cnt_q[i] != 2'd2);
      enq[i]   = port_if.req_valid_i[i] && ready[i] && !flush_i;
    end
  end

  assign port_if.req_ready_o = ready;

  // Round-robin scan from rr_q; k-th non-empty buffer goes to port k.
  always_comb begin
    logic [IDX_W:0]   sum;
    logic [IDX_W:0]   nxt;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] last;
    logic [CNT_W-1:0] k;
    port_vld = '0;
    granted  = '0;
    sum      = '0;
    nxt      = '0;
    idx      = '0;
    last     = '0;
    k        = '0;
    rr_d     = rr_q;
    for (int unsigned p = 0; p < NR_PORTS; p++) port_idx[p] = '0;
    for (int unsigned j = 0; j < NR_REQ; j++) begin
      sum = {1'b0, rr_q} + (IDX_W + 1)'(j);
      if (sum >= NR_REQ_L) sum = sum - NR_REQ_L;
      idx = sum[IDX_W-1:0];
      if (!rst && cnt_q[idx] != 2'd0 && k < NR_PORTS_L) begin
        for (int unsigned p = 0; p < NR_PORTS; p++) begin
          if (k == CNT_W'(p)) begin
            port_vld[p] = 1'b1;
            port_idx[p] = idx;
          end
        end
        granted[idx] = 1'b1;
        last         = idx;
        k            = k + CNT_W'(1);
      end
    end
    if (k != '0) begin
      nxt = {1'b0, last} + (IDX_W + 1)'(1);
      if (nxt == NR_REQ_L) nxt = '0;
      rr_d = nxt[IDX_W-1:0];
    end
  end

  always_comb begin
    entry_t e;
    e = '0;
    for (int unsigned p = 0; p < NR_PORTS; p++) begin
      port_if.wb_valid_o[p]    = port_vld[p];
      port_if.compl_valid_o[p] = port_vld[p];
      port_if.wb_data_o[p]     = '0;
      port_if.wb_rd_o[p]       = '0;
      port_if.compl_id_o[p]    = '0;
      if (port_vld[p]) begin
        e = buf_q[port_idx[p]][head_q[port_idx[p]]];
        port_if.wb_data_o[p]  = e.data;
        port_if.wb_rd_o[p]    = e.rd;
        port_if.compl_id_o[p] = e.id;
      end
    end
  end

  // Buffer occupancy and the saturating stall counter.
  always_comb begin
    logic any_stall;
    any_stall   = 1'b0;
    stall_cnt_d = stall_cnt_q;
    for (int unsigned i = 0; i < NR_REQ; i++) begin
      head_d[i] = head_q[i] ^ granted[i];
      if (flush_i) cnt_d[i] = 2'd0;
      else         cnt_d[i] = cnt_q[i] - {1'b0, granted[i]} + {1'b0, enq[i]};
      if (cnt_q[i] != 2'd0 && !granted[i]) any_stall = 1'b1;
    end
    if (any_stall && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NR_REQ; i++) cnt_q[i] <= 2'd0;
      head_q      <= '0;
      rr_q        <= '0;
      stall_cnt_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NR_REQ; i++) cnt_q[i] <= cnt_d[i];
      head_q      <= head_d;
      rr_q        <= rr_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Payload storage needs no reset; occupancy is tracked by cnt_q.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NR_REQ; i++) begin
      if (enq[i]) begin
        buf_q[i][head_q[i] ^ cnt_q[i][0]] <= {port_if.req_data_i[i], port_if.req_id_i[i],
                                              port_if.req_rd_i[i]};
      end
    end
  end

  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: per-requester expected queues plus a
// reference round-robin model checked every cycle, with directed scenarios.
module tb_wb_port_arbiter;
  localparam int unsigned NR_REQ   = 4;
  localparam int unsigned NR_PORTS = 2;
  localparam int unsigned DATA_W   = 64;
  localparam int unsigned ID_W     = 6;
  localparam int unsigned RD_W     = 6;

  typedef struct {
    logic [63:0] data;
    logic [5:0]  id;
    logic [5:0]  rd;
  } res_t;

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic        flush = 1'b0;
  logic [31:0] stall_cnt;

  wb_port_arbiter_if #(.NR_REQ(NR_REQ), .NR_PORTS(NR_PORTS), .DATA_W(DATA_W),
                       .ID_W(ID_W), .RD_W(RD_W)) bus ();

  wb_port_arbiter #(.NR_REQ(NR_REQ), .NR_PORTS(NR_PORTS), .DATA_W(DATA_W),
                    .ID_W(ID_W), .RD_W(RD_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (flush),
    .port_if    (bus),
    .stall_cnt_o(stall_cnt)
  );

  always #5 clk = ~clk;

  res_t        pend [NR_REQ][$];
  res_t        sbq  [NR_REQ][$];
  int unsigned rr_m;
  logic [31:0] stall_m;
  logic [3:0]  seq [NR_REQ];
  int          n_chk, n_fail;
  bit          mon_en;
  int          held3, out3;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic res_t mk(input int r);
    res_t t;
    t.id   = {2'(r), seq[r]};
    seq[r] = seq[r] + 4'd1;
    t.data = {$urandom, $urandom};
    t.rd   = 6'($urandom);
    return t;
  endfunction

  function automatic bit busy();
    for (int i = 0; i < NR_REQ; i++)
      if (pend[i].size() > 0 || sbq[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  // One clock: drive pending results, check outputs against the model, advance the model.
  task automatic tick();
    int         g [2];
    int         ng;
    logic [1:0] m_exp;
    logic [3:0] rdy_m, gm, acc;
    logic       any_st;
    res_t       e;
    for (int i = 0; i < NR_REQ; i++) begin
      if (pend[i].size() > 0) begin
        bus.req_valid_i[i] = 1'b1;
        bus.req_data_i[i]  = pend[i][0].data;
        bus.req_id_i[i]    = pend[i][0].id;
        bus.req_rd_i[i]    = pend[i][0].rd;
      end else begin
        bus.req_valid_i[i] = 1'b0;
        bus.req_data_i[i]  = '0;
        bus.req_id_i[i]    = '0;
        bus.req_rd_i[i]    = '0;
      end
    end
    #1;
    ng = 0; g[0] = 0; g[1] = 0; m_exp = '0; gm = '0;
    for (int i = 0; i < NR_REQ; i++) rdy_m[i] = (sbq[i].size() < 2);
    if (!rst) begin
      for (int j = 0; j < NR_REQ; j++) begin
        int r;
        r = int'((rr_m + j) % NR_REQ);
        if (sbq[r].size() > 0 && ng < NR_PORTS) begin
          g[ng] = r; gm[r] = 1'b1; m_exp[ng] = 1'b1; ng++;
        end
      end
    end
    if (mon_en) begin
      check_eq("req_ready", 64'(bus.req_ready_o), 64'(rdy_m));
      check_eq("wb_valid", 64'(bus.wb_valid_o), 64'(m_exp));
      check_eq("compl_valid", 64'(bus.compl_valid_o), 64'(m_exp));
      check_eq("stall_cnt", 64'(stall_cnt), 64'(stall_m));
      for (int p = 0; p < NR_PORTS; p++) begin
        if (m_exp[p]) begin
          e = sbq[g[p]][0];
          check_eq($sformatf("wb_data[%0d]", p), bus.wb_data_o[p], e.data);
          check_eq($sformatf("wb_rd[%0d]", p), 64'(bus.wb_rd_o[p]), 64'(e.rd));
          check_eq($sformatf("compl_id[%0d]", p), 64'(bus.compl_id_o[p]), 64'(e.id));
        end else begin
          check_eq($sformatf("idle_data[%0d]", p), bus.wb_data_o[p], 64'd0);
        end
      end
    end
    if (rst) begin
      for (int i = 0; i < NR_REQ; i++) sbq[i].delete();
      rr_m    = 0;
      stall_m = '0;
    end else begin
      if (bus.req_valid_i[3] && !bus.req_ready_o[3]) held3++;
      acc    = bus.req_valid_i & bus.req_ready_o;
      any_st = 1'b0;
      for (int i = 0; i < NR_REQ; i++)
        if (sbq[i].size() > 0 && !gm[i]) any_st = 1'b1;
      if (any_st && stall_m != 32'hFFFF_FFFF) stall_m = stall_m + 32'd1;
      for (int p = 0; p < ng; p++) begin
        void'(sbq[g[p]].pop_front());
        if (g[p] == 3) out3++;
      end
      if (ng > 0) rr_m = (g[ng-1] + 1) % NR_REQ;
      for (int i = 0; i < NR_REQ; i++) begin
        if (flush) sbq[i].delete();
        if (acc[i] === 1'b1) begin
          e = pend[i].pop_front();
          if (!flush) sbq[i].push_back(e);
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    for (int i = 0; i < NR_REQ; i++) pend[i].delete();
    rst = 1'b1;
    repeat (2) tick();
    rst    = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (busy() && n < budget) begin
      tick();
      n++;
    end
    check_eq("drain_done", 64'(busy()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    res_t lone;
    n_chk = 0; n_fail = 0; mon_en = 1'b0; held3 = 0; out3 = 0;
    rr_m = 0; stall_m = '0;
    for (int i = 0; i < NR_REQ; i++) seq[i] = '0;
    bus.req_valid_i = '0; bus.req_data_i = '0; bus.req_id_i = '0; bus.req_rd_i = '0;

    do_reset();
    #1;
    check_eq("rst_ready", 64'(bus.req_ready_o), 64'hF);
    check_eq("rst_wb_valid", 64'(bus.wb_valid_o), 64'd0);
    check_eq("rst_stall", 64'(stall_cnt), 64'd0);
    check_eq("rst_rr_ptr", 64'(dut.rr_q), 64'd0);

    // Lone request from req0
    lone.id = 6'd5; lone.data = 64'hAA; lone.rd = 6'd9;
    pend[0].push_back(lone);
    tick();
    #1;
    check_eq("lone_wb_valid", 64'(bus.wb_valid_o), 64'h1);
    check_eq("lone_data", bus.wb_data_o[0], 64'hAA);
    check_eq("lone_id", 64'(bus.compl_id_o[0]), 64'd5);
    check_eq("lone_rd", 64'(bus.wb_rd_o[0]), 64'd9);
    tick();
    #1;
    check_eq("lone_rr_ptr", 64'(dut.rr_q), 64'd1);

    // Round-robin fairness from rr_ptr=0
    do_reset();
    for (int i = 0; i < NR_REQ; i++) pend[i].push_back(mk(i));
    tick();
    #1;
    check_eq("rr_c1_valid", 64'(bus.wb_valid_o), 64'h3);
    check_eq("rr_c1_p0_req", 64'(bus.compl_id_o[0][5:4]), 64'd0);
    check_eq("rr_c1_p1_req", 64'(bus.compl_id_o[1][5:4]), 64'd1);
    tick();
    #1;
    check_eq("rr_c2_valid", 64'(bus.wb_valid_o), 64'h3);
    check_eq("rr_c2_p0_req", 64'(bus.compl_id_o[0][5:4]), 64'd2);
    check_eq("rr_c2_p1_req", 64'(bus.compl_id_o[1][5:4]), 64'd3);
    check_eq("rr_c2_stall", 64'(stall_cnt), 64'd1);
    tick();
    #1;
    check_eq("rr_c3_valid", 64'(bus.wb_valid_o), 64'd0);

    // Backpressure on req3 while req0..2 keep their buffers busy
    do_reset();
    held3 = 0; out3 = 0;
    for (int k = 0; k < 6; k++)
      for (int i = 0; i < 3; i++) pend[i].push_back(mk(i));
    for (int k = 0; k < 3; k++) pend[3].push_back(mk(3));
    drain(100);
    check_eq("bp_req3_held", 64'(held3 > 0), 64'd1);
    check_eq("bp_req3_out", 64'(out3), 64'd3);

    // Flush with five buffered results and new pushes in the flush cycle
    do_reset();
    for (int i = 0; i < NR_REQ; i++) pend[i].push_back(mk(i));
    tick();
    for (int i = 0; i < 3; i++) pend[i].push_back(mk(i));
    tick();
    #1;
    check_eq("flush_pre_ready", 64'(bus.req_ready_o), 64'hB);
    for (int i = 0; i < NR_REQ; i++) pend[i].push_back(mk(i));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    check_eq("flush_wb_valid", 64'(bus.wb_valid_o), 64'd0);
    check_eq("flush_ready", 64'(bus.req_ready_o), 64'hF);
    drain(50);

    // Reset mid-operation with three buffered results
    for (int i = 0; i < 3; i++) pend[i].push_back(mk(i));
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check_eq("rstmid_ready", 64'(bus.req_ready_o), 64'hF);
    check_eq("rstmid_wb_valid", 64'(bus.wb_valid_o), 64'd0);
    check_eq("rstmid_stall", 64'(stall_cnt), 64'd0);
    check_eq("rstmid_rr_ptr", 64'(dut.rr_q), 64'd0);
    pend[2].push_back(mk(2));
    tick();
    #1;
    check_eq("rstmid_push_valid", 64'(bus.wb_valid_o), 64'h1);
    check_eq("rstmid_push_req", 64'(bus.compl_id_o[0][5:4]), 64'd2);
    drain(10);

    // Stall counter saturation under a permanent 3-requester conflict
    for (int k = 0; k < 30; k++)
      for (int i = 0; i < 3; i++) pend[i].push_back(mk(i));
    repeat (6) tick();
    force dut.stall_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt_q;
    stall_m = 32'hFFFF_FFFE;
    check_eq("sat_preset", 64'(stall_cnt), 64'hFFFF_FFFE);
    tick();
    #1;
    check_eq("sat_reach", 64'(stall_cnt), 64'hFFFF_FFFF);
    repeat (4) tick();
    #1;
    check_eq("sat_hold", 64'(stall_cnt), 64'hFFFF_FFFF);
    for (int i = 0; i < NR_REQ; i++) pend[i].delete();
    drain(50);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares a small number of register-file write-back ports between a larger set of functional-unit result producers (ALU, LSU, CSR/misc, DIV, ...).
- Each requester gets a 2-entry result buffer, so single-cycle FUs can hand off a result even when no port is free.
- A round-robin scheduler grants up to NR_PORTS buffered results per cycle and drives the write-back and completion ports.
- Sits between the FU cluster outputs and the register file / ROB completion logic. It replaces the fixed one-FU-per-port wiring.

Parameters:
- NR_REQ, 4, number of requesting functional units (≥2).
- NR_PORTS, 2, number of write-back ports (1..NR_REQ).
- DATA_W, 64, width of the write-back result payload.
- ID_W, 6, width of the ROB id carried with each result.
- RD_W, 6, width of the physical destination register index.

Ports:
- clk  in  1  core clock.
- rst  in  1  reset, synchronous, active-high.
- flush_i  in  1  pipeline flush; drops all buffered results.
- req_valid_i  in  NR_REQ  result valid per requester.
- req_ready_o  out  NR_REQ  requester buffer can accept.
- req_data_i  in  NR_REQ x DATA_W  result payload.
- req_id_i  in  NR_REQ x ID_W  ROB id.
- req_rd_i  in  NR_REQ x RD_W  destination register.
- wb_valid_o  out  NR_PORTS  write-back valid per port.
- wb_data_o  out  NR_PORTS x DATA_W  write-back payload.
- wb_rd_o  out  NR_PORTS x RD_W  write-back destination.
- compl_valid_o  out  NR_PORTS  completion valid; equals wb_valid_o.
- compl_id_o  out  NR_PORTS x ID_W  completion ROB id.
- stall_cnt_o  out  32  saturating count of cycles with ≥1 buffered result left ungranted.

Behaviour:
- **Interface decision:** one clock, clk; reset rst is synchronous and active-high.
- **Reset:**
  - All buffers empty, rr_ptr=0, stall_cnt_o=0.
  - req_ready_o all 1.
  - wb_valid_o/compl_valid_o all 0. Data outputs are don't-care but driven to 0.
- **Per-requester buffer:**
  - 2-entry FIFO with count 0..2.
  - req_ready_o[i] = (count_i < 2), derived from the registered count only. No same-cycle dequeue bypass, so a full buffer reports not-ready even while it is being drained.
  - Enqueue on req_valid_i[i] && req_ready_o[i] at the clk edge.
  - A valid without ready is ignored; the requester must hold it.
- **Arbitration (combinational, each cycle):**
  - Scan requesters starting at rr_ptr, wrapping modulo NR_REQ.
  - The k-th non-empty buffer found (k < NR_PORTS) is granted to port k. At most one head per requester per cycle.
  - Granted heads drive wb_* and compl_* in the same cycle. Granted entries are dequeued at the edge.
- **Latency:** a result accepted at edge t is first visible on a wb port in cycle t+1 (t = cycle of handshake). Minimum buffer-to-port latency is 1 cycle. Write-back ports have no backpressure.
- **Pointer update:**
  - If ≥1 grant: rr_ptr <= (index of last granted requester + 1) mod NR_REQ.
  - Otherwise rr_ptr holds.
  - Guarantees starvation freedom: every non-empty buffer is granted within ceil(NR_REQ/NR_PORTS) cycles.
- **Simultaneous enqueue/dequeue on the same buffer:**
  - Both take effect; count stays the same.
  - FIFO order per requester is preserved; results from one FU never reorder.
- **Flush:**
  - flush_i=1: all counts cleared at the edge, and enqueues that cycle are discarded.
  - wb_valid_o is still driven combinationally during the flush cycle; consumers gate with their own flush.
  - rr_ptr is not reset.
  - rst has priority over flush_i.
- **stall_cnt_o:**
  - Increments by 1 when any buffer is non-empty and not granted this cycle.
  - Saturates at 0xFFFF_FFFF. Cleared only by rst.
- **Ordering rules:**
  - Port index assignment is positional only. Port 0 always receives the first grant, so wb_valid_o is always a contiguous low-order mask.
  - rst asserted mid-operation drops all buffered results without emitting them.

Test Plan:
- Use NR_REQ=4, NR_PORTS=2 for all scenarios.
- **Lone request:** req_valid_i=0001, id=5, data=0xAA at cycle 0 → cycle 1: wb_valid_o=01, wb_data_o[0]=0xAA, compl_id_o[0]=5; rr_ptr=1.
- **Round-robin fairness:** all four requesters push one result each in cycle 0 (rr_ptr=0) → cycle 1 grants req0→port0, req1→port1; cycle 2 grants req2, req3; stall_cnt_o=1.
- **Backpressure:** req3 pushes 3 consecutive cycles while req0–2 stay saturated → req_ready_o[3]=0 after two accepts; third push held until a slot frees. All three of req3's ids emerge in order.
- **Flush:** buffers hold 5 results, flush_i pulses 1 cycle with new req_valid_i=1111 → next cycle wb_valid_o=00, req_ready_o=1111, no discarded id ever appears.
- **Reset mid-operation:** rst pulses while 3 results are buffered → next cycle all outputs at reset values, stall_cnt_o=0, and a subsequent single push reaches port 0 after 1 cycle.
- **Saturation:** force stall_cnt to 0xFFFF_FFFE with a permanent 3-requester conflict → value reaches 0xFFFF_FFFF and holds.
